// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at accept and committed to HI/LO when the busy countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0]      count;
  logic [63:0]        pend;
  logic               pend_skip;
  logic               accept;
  logic               is_div;
  logic               div_ovf;
  logic [31:0]        div_b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [63:0]        result_next;

  // Handshake: an op is taken on a rising edge with start=1 and busy=0; while busy=1
  // every start is ignored and stall_req holds the instruction in EX until busy falls.
  assign busy      = (count != '0);
  assign stall_req = busy | (start & (MDUOp >= OP_MULT) & (MDUOp <= OP_MFLO));
  assign accept    = start & ~busy & (MDUOp >= OP_MULT) & (MDUOp <= OP_DIVU);
  assign is_div    = (MDUOp == OP_DIV) | (MDUOp == OP_DIVU);

  always_comb begin
    div_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Safe divisor keeps the dividers defined for B=0 and the signed overflow case.
    div_b       = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
    prod_s      = 64'($signed(A)) * 64'($signed(B));
    prod_u      = {32'd0, A} * {32'd0, B};
    q_s         = $signed(A) / $signed(div_b);
    r_s         = $signed(A) % $signed(div_b);
    q_u         = A / div_b;
    r_u         = A % div_b;
    result_next = 64'd0;
    case (MDUOp)
      OP_MULT:  result_next = prod_s;
      OP_MULTU: result_next = prod_u;
      OP_DIV:   result_next = div_ovf ? {32'd0, 32'h8000_0000} : {r_s, q_s};
      OP_DIVU:  result_next = {r_u, q_u};
      default:  result_next = 64'd0;
    endcase
  end

  always_comb begin
    MDUresult = 32'd0;
    if (MDUOp == OP_MFHI)      MDUresult = HI;
    else if (MDUOp == OP_MFLO) MDUresult = LO;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      pend      <= 64'd0;
      pend_skip <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else if (accept) begin
      count     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend      <= result_next;
      pend_skip <= is_div && (B == 32'd0);
    end else if (busy) begin
      count <= count - 1'b1;
      if ((count == CW'(1)) && !pend_skip) begin
        HI <= pend[63:32];
        LO <= pend[31:0];
      end
    end else if (start && (MDUOp == OP_MTHI)) begin
      HI <= A;
    end else if (start && (MDUOp == OP_MTLO)) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model,
// with a scoreboard monitor that checks HI/LO and busy length whenever busy falls.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUresult;

  int checks = 0;
  int errors = 0;

  logic [79:0] exp_q[$];
  logic [79:0] mon_e;
  logic        prev_busy = 1'b0;
  int          busy_len  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
    .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO), .MDUresult(MDUresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = cur;
    case (op)
      4'd1: ref_result = sa * sb;
      4'd2: ref_result = ua * ub;
      4'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        ref_result = {r[31:0], q[31:0]};
      end
      4'd4: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        ref_result = {ur[31:0], uq[31:0]};
      end
      default: ref_result = cur;
    endcase
  endfunction

  // Monitor: every falling edge of busy retires the oldest outstanding mult/div.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: busy fell with got no pending entry, expected none to retire");
        end else begin
          mon_e = exp_q.pop_front();
          check("retire_hilo", {HI, LO}, mon_e[63:0]);
          check("busy_cycles", 64'(busy_len), {48'd0, mon_e[79:64]});
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic idle_inputs;
    start = 1'b0;
    MDUOp = 4'($urandom_range(0, 15));
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic wait_idle;
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy got stuck high, expected low within 64 cycles");
    end
  endtask

  // Presents one op for a single edge and updates the model; leaves the caller one negedge later.
  task automatic issue_nowait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    if (op >= 4'd1 && op <= 4'd4) begin
      e = ref_result(op, a, b, {m_hi, m_lo});
      exp_q.push_back({(op <= 4'd2) ? 16'd5 : 16'd10, e});
      {m_hi, m_lo} = e;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue_nowait(op, a, b);
    if (op >= 4'd1 && op <= 4'd4) wait_idle();
    else check("move_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  task automatic read_check(input logic [3:0] op);
    @(negedge clk);
    start = 1'b1;
    MDUOp = op;
    #1;
    check("read_stall", {63'd0, stall_req}, 64'd1);
    check("read_result", {32'd0, MDUresult}, {32'd0, (op == 4'd7) ? m_hi : m_lo});
    start = 1'b0;
  endtask

  task automatic junk_check(input logic [3:0] op);
    @(negedge clk);
    start = 1'b1;
    MDUOp = op;
    A     = $urandom;
    B     = $urandom;
    #1;
    check("junk_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("junk_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] save_hi;
  logic [3:0]  rop;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    MDUOp   = 4'd0;
    A       = 32'd0;
    B       = 32'd0;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_stall", {63'd0, stall_req}, 64'd0);
    check("reset_result", {32'd0, MDUresult}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("spec_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("spec_multu", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    issue_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    check("spec_div", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("spec_div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
    issue_op(4'd5, 32'h1234, 32'd0);
    issue_op(4'd6, 32'h5678, 32'd0);
    issue_op(4'd4, 32'hDEAD_BEEF, 32'd0);
    check("spec_divu_zero", {HI, LO}, 64'h0000_1234_0000_5678);
    read_check(4'd7);
    read_check(4'd8);
    junk_check(4'd0);
    junk_check(4'd12);

    // mtlo/mfhi presented during a multiply are held off and do not disturb the result.
    save_hi = m_hi;
    issue_nowait(4'd1, 32'h0001_2345, 32'hFFFF_0003);
    @(negedge clk);
    start = 1'b1;
    MDUOp = 4'd6;
    A     = 32'hAAAA_5555;
    #1;
    check("midop_stall_mtlo", {63'd0, stall_req}, 64'd1);
    @(negedge clk);
    MDUOp = 4'd7;
    #1;
    check("midop_stall_mfhi", {63'd0, stall_req}, 64'd1);
    check("midop_mfhi_old", {32'd0, MDUresult}, {32'd0, save_hi});
    start = 1'b0;
    wait_idle();
    read_check(4'd8);

    // Reset during a divide aborts it immediately.
    issue_nowait(4'd3, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // mtlo in the cycle busy falls is taken on the very next edge.
    issue_nowait(4'd2, 32'h0000_FFFF, 32'h0001_0001);
    wait_idle();
    start = 1'b1;
    MDUOp = 4'd6;
    A     = 32'd7;
    m_lo  = 32'd7;
    @(negedge clk);
    MDUOp = 4'd8;
    #1;
    check("b2b_mflo", {32'd0, MDUresult}, 64'd7);
    check("b2b_hi", {32'd0, HI}, {32'd0, m_hi});
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(1, 6));
      issue_op(rop, rand_operand(), rand_operand());
      case ($urandom_range(0, 3))
        0: read_check(4'd7);
        1: read_check(4'd8);
        2: junk_check(4'($urandom_range(9, 15)));
        default: ;
      endcase
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
